// File: rtl/plugboard_if.sv
// ---------------------------------------------------------------------------
// plugboard_if
//   Bundles the key/table-programming handshake and the plugboard letter
//   paths of plugboard_ctrl.
//
//   master (keyboard / rotor side, drives requests):
//     key_valid      1-cycle pulse, key_code is valid
//     key_code[4:0]  letter index 0..25, 26..31 illegal
//     prog_mode      1 = keys edit the pair table, 0 = keys encrypt
//     clear_all      pulse, remove every pair
//     rear_in[25:0]  one-hot letter from the rotor/reflector output
//   slave (plugboard, drives results):
//     ready               key_valid is accepted this cycle
//     front_plug_out[25:0] swapped one-hot key letter
//     front_valid         pulse when front_plug_out updates
//     rear_plug_out[25:0] swapped one-hot rear letter
//     pair_count[3:0]     pairs currently installed
//     err                 pulse on a rejected key event
// ---------------------------------------------------------------------------
interface plugboard_if;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        prog_mode;
  logic        clear_all;
  logic [25:0] rear_in;
  logic        ready;
  logic [25:0] front_plug_out;
  logic        front_valid;
  logic [25:0] rear_plug_out;
  logic [3:0]  pair_count;
  logic        err;

  modport master (
    output key_valid, key_code, prog_mode, clear_all, rear_in,
    input  ready, front_plug_out, front_valid, rear_plug_out, pair_count, err
  );

  modport slave (
    input  key_valid, key_code, prog_mode, clear_all, rear_in,
    output ready, front_plug_out, front_valid, rear_plug_out, pair_count, err
  );
endinterface

// File: rtl/plugboard_ctrl.sv
// ---------------------------------------------------------------------------
// plugboard_ctrl
//   Programmable Enigma plugboard. A 26-entry involutive swap table maps the
//   keyed letter into the rotor stage (front path) and maps the rotor stage
//   output back out (rear path). In programming mode, pairs of keys add or
//   remove a letter pair; each edit is committed over two write cycles.
//
//   Ports:
//     CLOCK_50  system clock, rising edge
//     reset     synchronous, active-high reset
//     bus       plugboard_if.slave (key handshake, letter paths, status)
//
//   Parameter:
//     MAX_PAIRS maximum simultaneous letter pairs
// ---------------------------------------------------------------------------
module plugboard_ctrl #(
  parameter int MAX_PAIRS = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  plugboard_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG_FIRST,
    S_PROG_SECOND,
    S_WRITE_A,
    S_WRITE_B
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_table [26];
  logic [4:0]  r_a;          // first letter of the pair being programmed
  logic [4:0]  r_wr_a;       // entry written in WRITE_A
  logic [4:0]  r_wr_b;       // entry written in WRITE_B
  logic        r_pair;       // 1 = installing a pair, 0 = removing one
  logic [3:0]  r_pair_count;
  logic [25:0] r_front;
  logic        r_front_valid;
  logic [25:0] r_rear;
  logic        r_err;

  // Decode of the current key and the table entries it touches.
  logic        w_key_legal;
  logic [4:0]  w_key_idx;
  logic [4:0]  w_tab_a;
  logic [4:0]  w_tab_k;

  // Actions requested by the next-state logic for this cycle.
  logic        w_clear;
  logic        w_front_load;
  logic        w_err_set;
  logic        w_latch_a;
  logic        w_start_write;
  logic [4:0]  w_wr_a;
  logic [4:0]  w_wr_b;
  logic        w_pair;

  // Rear path decode.
  logic        w_rear_single;
  logic [4:0]  w_rear_idx;

  // Illegal codes are clamped to 0 so the table is never indexed out of
  // range; every use of w_key_idx is qualified by w_key_legal.
  assign w_key_legal = (bus.key_code < 5'd26);
  assign w_key_idx   = w_key_legal ? bus.key_code : 5'd0;
  assign w_tab_a     = r_table[r_a];
  assign w_tab_k     = r_table[w_key_idx];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state and action decode
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_next        = r_state;
    w_clear       = 1'b0;
    w_front_load  = 1'b0;
    w_err_set     = 1'b0;
    w_latch_a     = 1'b0;
    w_start_write = 1'b0;
    w_wr_a        = r_a;
    w_wr_b        = w_key_idx;
    w_pair        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.clear_all) begin
          w_clear = 1'b1;
          w_next  = bus.prog_mode ? S_PROG_FIRST : S_IDLE;
        end else if (bus.prog_mode) begin
          w_next = S_PROG_FIRST;
        end else if (bus.key_valid) begin
          if (w_key_legal) w_front_load = 1'b1;
          else             w_err_set    = 1'b1;
        end
      end

      S_PROG_FIRST, S_PROG_SECOND: begin
        if (bus.clear_all) begin
          w_clear = 1'b1;
          w_next  = bus.prog_mode ? S_PROG_FIRST : S_IDLE;
        end else if (!bus.prog_mode) begin
          w_next = S_IDLE;
        end else if (bus.key_valid) begin
          if (!w_key_legal) begin
            w_err_set = 1'b1;
          end else if (r_state == S_PROG_FIRST) begin
            w_latch_a = 1'b1;
            w_next    = S_PROG_SECOND;
          end else begin
            w_next = S_PROG_FIRST;
            if (r_a == w_key_idx) begin
              // Same key twice: unplug A from its partner, if it has one.
              if (w_tab_a != r_a) begin
                w_start_write = 1'b1;
                w_wr_b        = w_tab_a;
              end
            end else if (w_tab_a == w_key_idx) begin
              // A and B are already partners: remove the pair.
              w_start_write = 1'b1;
            end else if ((w_tab_a != r_a) || (w_tab_k != w_key_idx)) begin
              w_err_set = 1'b1;
            end else if (r_pair_count == 4'(MAX_PAIRS)) begin
              w_err_set = 1'b1;
            end else begin
              w_start_write = 1'b1;
              w_pair        = 1'b1;
            end
            if (w_start_write) w_next = S_WRITE_A;
          end
        end
      end

      S_WRITE_A: w_next = S_WRITE_B;
      S_WRITE_B: w_next = S_PROG_FIRST;
      default:   w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.ready = (r_state == S_IDLE) || (r_state == S_PROG_FIRST) ||
                (r_state == S_PROG_SECOND);
  end

  // ---------------------------------------------------------------------
  // Swap table, pair counter and edit bookkeeping
  // ---------------------------------------------------------------------
  // NOTE: the table is a 26-entry register file, not a RAM, so it can and
  // must be reset: identity is the only legal power-up content.
  always_ff @(posedge CLOCK_50) begin
    if (reset || w_clear) begin
      for (int i = 0; i < 26; i++) r_table[i] <= 5'(i);
      r_pair_count <= 4'd0;
    end else if (r_state == S_WRITE_A) begin
      r_table[r_wr_a] <= r_pair ? r_wr_b : r_wr_a;
    end else if (r_state == S_WRITE_B) begin
      // The table is briefly non-involutive between the two writes; the FSM
      // holds ready low so nothing but the rear path can observe it.
      r_table[r_wr_b] <= r_pair ? r_wr_a : r_wr_b;
      r_pair_count    <= r_pair ? r_pair_count + 4'd1 : r_pair_count - 4'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_a    <= 5'd0;
      r_wr_a <= 5'd0;
      r_wr_b <= 5'd0;
      r_pair <= 1'b0;
    end else begin
      if (w_latch_a) r_a <= w_key_idx;
      if (w_start_write) begin
        r_wr_a <= w_wr_a;
        r_wr_b <= w_wr_b;
        r_pair <= w_pair;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Front path: registered one-cycle pulse; output holds between keys so a
  // later table edit never rewrites an already-issued letter.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_front       <= '0;
      r_front_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_front_valid <= w_front_load;
      r_err         <= w_err_set;
      if (w_front_load) r_front <= 26'd1 << w_tab_k;
    end
  end

  // ---------------------------------------------------------------------
  // Rear path: runs every cycle regardless of FSM state.
  // ---------------------------------------------------------------------
  assign w_rear_single = (bus.rear_in != '0) &&
                         ((bus.rear_in & (bus.rear_in - 26'd1)) == '0);

  always_comb begin
    w_rear_idx = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (bus.rear_in[i]) w_rear_idx = 5'(i);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)              r_rear <= '0;
    else if (w_rear_single) r_rear <= 26'd1 << r_table[w_rear_idx];
    else                    r_rear <= '0;
  end

  assign bus.front_plug_out = r_front;
  assign bus.front_valid    = r_front_valid;
  assign bus.rear_plug_out  = r_rear;
  assign bus.pair_count     = r_pair_count;
  assign bus.err            = r_err;

endmodule

// File: tb/tb_plugboard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_plugboard_ctrl
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A behavioural model (whole-table commits, a busy countdown for
//   the write window) predicts every output; a compare process checks the
//   DUT against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_plugboard_ctrl;

  localparam int MAX_PAIRS = 10;

  logic clk;
  logic reset;
  plugboard_if bus ();

  plugboard_ctrl #(.MAX_PAIRS(MAX_PAIRS)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  int          m_tab [26];
  int          m_new [26];
  int          m_count;
  int          m_new_count;
  int          m_mode;      // 0 encrypt, 1 waiting first key, 2 waiting second
  int          m_busy;      // remaining write cycles after an accepted edit
  int          m_a;
  logic [25:0] e_front;
  logic [25:0] e_rear;
  logic        e_fv;
  logic        e_err;
  logic        e_rear_known;

  always @(posedge clk) begin
    int k;
    int ridx;
    k = int'(bus.key_code);
    if (reset) begin
      for (int i = 0; i < 26; i++) m_tab[i] = i;
      m_count = 0; m_mode = 0; m_busy = 0; m_a = 0;
      e_front = '0; e_rear = '0; e_fv = 1'b0; e_err = 1'b0;
      e_rear_known = 1'b1;
    end else begin
      // The second write cycle sees a half-updated table; its rear result
      // is not defined by the committed table.
      e_rear_known = (m_busy != 1);
      if ($countones(bus.rear_in) == 1) begin
        ridx = 0;
        for (int i = 0; i < 26; i++) if (bus.rear_in[i]) ridx = i;
        e_rear = 26'd1 << m_tab[ridx];
      end else begin
        e_rear = '0;
      end
      e_fv  = 1'b0;
      e_err = 1'b0;

      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_tab   = m_new;
          m_count = m_new_count;
          m_mode  = 1;
        end
      end else if (bus.clear_all) begin
        for (int i = 0; i < 26; i++) m_tab[i] = i;
        m_count = 0;
        m_mode  = bus.prog_mode ? 1 : 0;
      end else if (m_mode == 0) begin
        if (bus.prog_mode) m_mode = 1;
        else if (bus.key_valid) begin
          if (k < 26) begin
            e_front = 26'd1 << m_tab[k];
            e_fv    = 1'b1;
          end else begin
            e_err = 1'b1;
          end
        end
      end else if (!bus.prog_mode) begin
        m_mode = 0;
      end else if (bus.key_valid) begin
        if (k >= 26) e_err = 1'b1;
        else if (m_mode == 1) begin
          m_a    = k;
          m_mode = 2;
        end else begin
          m_new  = m_tab;
          m_mode = 1;
          if (m_a == k) begin
            if (m_tab[k] != k) begin
              m_new[m_tab[k]] = m_tab[k];
              m_new[k]        = k;
              m_new_count     = m_count - 1;
              m_busy          = 2;
            end
          end else if (m_tab[m_a] == k) begin
            m_new[m_a]  = m_a;
            m_new[k]    = k;
            m_new_count = m_count - 1;
            m_busy      = 2;
          end else if (m_tab[m_a] != m_a || m_tab[k] != k) begin
            e_err = 1'b1;
          end else if (m_count == MAX_PAIRS) begin
            e_err = 1'b1;
          end else begin
            m_new[m_a]  = k;
            m_new[k]    = m_a;
            m_new_count = m_count + 1;
            m_busy      = 2;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", 32'(bus.ready), 32'(m_busy == 0));
      check("m_front", 32'(bus.front_plug_out), 32'(e_front));
      check("m_front_valid", 32'(bus.front_valid), 32'(e_fv));
      check("m_err", 32'(bus.err), 32'(e_err));
      check("m_pair_count", 32'(bus.pair_count), 32'(m_count));
      if (e_rear_known) check("m_rear", 32'(bus.rear_plug_out), 32'(e_rear));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (inputs change just after a falling edge)
  // ---------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input int k);
    bus.key_code  = 5'(k);
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic program_pair(input int a, input int b);
    press(a);
    press(b);
    step();
    step();
  endtask

  initial begin
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    bus.prog_mode = 1'b0;
    bus.clear_all = 1'b0;
    bus.rear_in   = '0;
    step();
    chk_en = 1'b1;
    step();
    check("rst_pair_count", 32'(bus.pair_count), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_front", 32'(bus.front_plug_out), 32'd0);
    check("rst_rear", 32'(bus.rear_plug_out), 32'd0);
    reset = 1'b0;
    step();

    // Encrypt with identity table.
    press(0);
    check("id_front", 32'(bus.front_plug_out), 32'h1);
    check("id_front_valid", 32'(bus.front_valid), 32'd1);
    bus.rear_in = 26'h2;
    step();
    check("id_front_valid_drop", 32'(bus.front_valid), 32'd0);
    step();
    check("id_rear", 32'(bus.rear_plug_out), 32'h2);
    bus.rear_in = '0;

    // Install A-E.
    bus.prog_mode = 1'b1;
    step();
    press(0);
    press(4);
    check("ae_ready_wa", 32'(bus.ready), 32'd0);
    step();
    check("ae_ready_wb", 32'(bus.ready), 32'd0);
    step();
    check("ae_ready_back", 32'(bus.ready), 32'd1);
    check("ae_count", 32'(bus.pair_count), 32'd1);
    bus.prog_mode = 1'b0;
    step();
    press(4);
    check("ae_front", 32'(bus.front_plug_out), 32'h1);
    bus.rear_in = 26'h1;
    step();
    check("ae_rear", 32'(bus.rear_plug_out), 32'h10);
    bus.rear_in = '0;

    // Conflicting pair, then remove A-E.
    bus.prog_mode = 1'b1;
    step();
    press(0);
    press(7);
    check("conflict_err", 32'(bus.err), 32'd1);
    step();
    check("conflict_count", 32'(bus.pair_count), 32'd1);
    program_pair(4, 0);
    check("unpair_count", 32'(bus.pair_count), 32'd0);

    // Fill to the limit, reject one more, then clear.
    for (int p = 0; p < MAX_PAIRS; p++) program_pair(2 * p, 2 * p + 1);
    check("full_count", 32'(bus.pair_count), 32'd10);
    press(20);
    press(21);
    check("full_err", 32'(bus.err), 32'd1);
    step();
    check("full_count_hold", 32'(bus.pair_count), 32'd10);
    bus.clear_all = 1'b1;
    step();
    bus.clear_all = 1'b0;
    check("clear_count", 32'(bus.pair_count), 32'd0);
    bus.prog_mode = 1'b0;
    step();
    press(0);
    check("clear_front", 32'(bus.front_plug_out), 32'h1);

    // Illegal key in IDLE; multi-hot rear input.
    press(27);
    check("illegal_err", 32'(bus.err), 32'd1);
    check("illegal_fv", 32'(bus.front_valid), 32'd0);
    bus.rear_in = 26'h3;
    step();
    check("multihot_rear", 32'(bus.rear_plug_out), 32'd0);
    bus.rear_in = '0;

    // Reset while in WRITE_A.
    bus.prog_mode = 1'b1;
    step();
    press(5);
    press(6);
    check("wa_ready", 32'(bus.ready), 32'd0);
    reset         = 1'b1;
    bus.prog_mode = 1'b0;
    step();
    reset = 1'b0;
    check("wa_rst_count", 32'(bus.pair_count), 32'd0);
    check("wa_rst_ready", 32'(bus.ready), 32'd1);
    press(5);
    check("wa_rst_front", 32'(bus.front_plug_out), 32'h20);

    // Abort from PROG_SECOND leaves the table alone.
    bus.prog_mode = 1'b1;
    step();
    program_pair(2, 3);
    press(2);
    bus.prog_mode = 1'b0;
    step();
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_count", 32'(bus.pair_count), 32'd1);
    press(2);
    check("abort_front_c", 32'(bus.front_plug_out), 32'h8);
    press(3);
    check("abort_front_d", 32'(bus.front_plug_out), 32'h4);

    // Randomized traffic.
    bus.prog_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) bus.prog_mode = ~bus.prog_mode;
      bus.key_valid = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 1) == 1) bus.key_code = 5'($urandom_range(0, 31));
      else                           bus.key_code = 5'($urandom_range(0, 25));
      bus.clear_all = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0:       bus.rear_in = '0;
        3:       bus.rear_in = 26'($urandom);
        default: bus.rear_in = 26'd1 << $urandom_range(0, 25);
      endcase
      step();
    end
    reset         = 1'b0;
    bus.key_valid = 1'b0;
    bus.clear_all = 1'b0;
    step();
    step();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
